// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external memory bus: cycle codes and arbiter states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ext_bus_pkg;

  localparam int CMD_W = 3;

  // External cycle codes driven on ext_cmd. Codes 100-111 are reserved for IO cycles.
  localparam logic [CMD_W-1:0] CMD_IDLE  = 3'b000;
  localparam logic [CMD_W-1:0] CMD_FETCH = 3'b001;
  localparam logic [CMD_W-1:0] CMD_READ  = 3'b010;
  localparam logic [CMD_W-1:0] CMD_WRITE = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } bus_state_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state timer for an external bus cycle; expire flags the TIMEOUT-th cycle without ready.
// Latency: expire is combinational from en and the registered count.
// Backpressure: none; clr wins over en, the count parks at its last value once expired.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       zero the count (held while the bus is idle)
//   en        one more cycle has elapsed without ready
//   expire    this cycle is the TIMEOUT-th cycle counted by en
module bus_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the cycles already waited, so the current cycle is the TIMEOUT-th
  // when cnt has reached TIMEOUT-1.
  assign expire = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// External memory bus owner: arbitrates fetch vs load/store and runs one external cycle at a time.
// Latency: grant at cycle 0, ext_cmd from cycle 1, ready at cycle k, ack at cycle k+1.
// Backpressure: requesters hold req until ack; ext_ready stalls the cycle until TIMEOUT aborts it.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                fetch request, held until if_ack
//   if_ack/if_rdata/if_err        fetch completion pulse, instruction word, timeout flag
//   ls_req/ls_we/ls_addr/ls_wdata data request, held until ls_ack
//   ls_ack/ls_rdata/ls_err        data completion pulse, read data, timeout flag
//   ext_addr/ext_wdata/ext_oe     external address, write data, write-cycle output enable
//   ext_cmd/ext_ready/ext_rdata   external cycle code, completion handshake, read data
//   busy                          an external cycle is in progress
module ext_bus_arbiter
  import ext_bus_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  output logic              ext_oe,
  output logic [CMD_W-1:0]  ext_cmd,
  input  logic              ext_ready,
  output logic              busy
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  bus_state_t        state_q, state_d;
  logic [RUN_W-1:0]  run_cnt, run_d;
  logic [CMD_W-1:0]  cmd_d;
  logic              oe_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              if_ack_d, if_err_d, ls_ack_d, ls_err_d;
  logic [DATA_W-1:0] if_rdata_d, ls_rdata_d;
  logic              data_win;
  logic              timer_clr, timer_en, expire;

  // Data normally wins; a pending fetch is starved for at most MAX_DATA_RUN data grants.
  assign data_win = ls_req && (!if_req || (run_cnt < RUN_MAX));

  // The timer sits at zero while idle, so every grant starts it from zero.
  assign timer_clr = (state_q == S_IDLE);
  assign timer_en  = (state_q != S_IDLE) && !ext_ready;

  bus_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_cnt;
    cmd_d      = ext_cmd;
    oe_d       = ext_oe;
    addr_d     = ext_addr;
    wdata_d    = ext_wdata;
    if_ack_d   = 1'b0;
    if_err_d   = 1'b0;
    ls_ack_d   = 1'b0;
    ls_err_d   = 1'b0;
    if_rdata_d = if_rdata;
    ls_rdata_d = ls_rdata;

    case (state_q)
      S_IDLE: begin
        // ext_ready is deliberately ignored here.
        if (data_win) begin
          addr_d = ls_addr;
          // data_win with if_req implies run_cnt < RUN_MAX, so this never overflows.
          run_d  = if_req ? (run_cnt + RUN_W'(1)) : '0;
          if (ls_we) begin
            state_d = S_WRITE;
            cmd_d   = CMD_WRITE;
            oe_d    = 1'b1;
            wdata_d = ls_wdata;
          end else begin
            state_d = S_READ;
            cmd_d   = CMD_READ;
          end
        end else if (if_req) begin
          state_d = S_FETCH;
          cmd_d   = CMD_FETCH;
          addr_d  = if_addr;
          run_d   = '0;
        end
      end

      default: begin
        if (ext_ready || expire) begin
          state_d = S_IDLE;
          cmd_d   = CMD_IDLE;
          oe_d    = 1'b0;
          if (state_q == S_FETCH) begin
            if_ack_d = 1'b1;
            if_err_d = !ext_ready;
            if (ext_ready) begin
              if_rdata_d = ext_rdata;
            end
          end else begin
            ls_ack_d = 1'b1;
            ls_err_d = !ext_ready;
            if (ext_ready && (state_q == S_READ)) begin
              ls_rdata_d = ext_rdata;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt   <= '0;
      ext_cmd   <= CMD_IDLE;
      ext_oe    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      ls_ack    <= 1'b0;
      ls_err    <= 1'b0;
      ls_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      run_cnt   <= run_d;
      ext_cmd   <= cmd_d;
      ext_oe    <= oe_d;
      ext_addr  <= addr_d;
      ext_wdata <= wdata_d;
      if_ack    <= if_ack_d;
      if_err    <= if_err_d;
      if_rdata  <= if_rdata_d;
      ls_ack    <= ls_ack_d;
      ls_err    <= ls_err_d;
      ls_rdata  <= ls_rdata_d;
      busy      <= (state_d != S_IDLE);
    end
  end

endmodule
